// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline widths, ALU op encodings and control bit positions
package pipe_pkg;

    localparam int XLEN      = 32;
    localparam int OPC_W     = 14;
    localparam int CTRL_W    = 6;
    localparam int REG_IDX_W = 5;

    localparam int READ_MMU  = 0;
    localparam int WRITE_MMU = 1;
    localparam int BYTE_SEL  = 2;
    localparam int WRITE_REG = 3;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_MUL    = 4'd7,
        ALU_PASS8  = 4'd8,
        ALU_PASS9  = 4'd9,
        ALU_PASS10 = 4'd10,
        ALU_PASS11 = 4'd11,
        ALU_PASS12 = 4'd12,
        ALU_PASS13 = 4'd13,
        ALU_PASS14 = 4'd14,
        ALU_PASS15 = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        EX_IDLE     = 2'd0,
        EX_MUL_BUSY = 2'd1,
        EX_MUL_DONE = 2'd2
    } ex_state_e;

    // Single-cycle ops; MUL is produced by the iterative multiplier, so it falls to pass-B here.
    function automatic logic [XLEN-1:0] alu_compute(input logic [3:0] op,
                                                    input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SLL: r = a << b[4:0];
            ALU_SRL: r = a >> b[4:0];
            default: r = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/iter_mul.sv
// rtl/iter_mul.sv - 32-cycle shift-add multiplier, low 32 bits of an unsigned product
module iter_mul
    import pipe_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            hold_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] product_o
);

    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            busy_q, busy_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (abort_i) begin
            busy_d = 1'b0;
            acc_d  = '0;
            cnt_d  = '0;
        end else if (hold_i) begin
            busy_d = busy_q;
        end else if (load_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            // Partial product only needs the low 32 bits, so the multiplicand shifts out harmlessly.
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = busy_q && (cnt_q == 5'd31);
    assign product_o = acc_q;

endmodule

// File: rtl/ex_unit.sv
// rtl/ex_unit.sv - execute stage: ALU, iterative MUL sequencing and EX/MEM output latch
module ex_unit
    import pipe_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [XLEN-1:0]      next_pc_in,
    input  logic [OPC_W-1:0]     opcode_in,
    input  logic [XLEN-1:0]      rgS1_data_in,
    input  logic [XLEN-1:0]      rgS2_data_in,
    input  logic [XLEN-1:0]      immed_in,
    input  logic                 y_sel_in,
    input  logic [CTRL_W-1:0]    control_in,
    input  logic [REG_IDX_W-1:0] rgD_index_in,
    input  logic                 flush,
    input  logic                 mem_stall,
    output logic                 stall_out,
    output logic                 out_valid,
    output logic [XLEN-1:0]      result_out,
    output logic [XLEN-1:0]      store_data_out,
    output logic [XLEN-1:0]      next_pc_out,
    output logic [CTRL_W-1:0]    control_out,
    output logic [REG_IDX_W-1:0] rgD_index_out
);

    ex_state_e            state_q, state_d;
    logic                 valid_q, valid_d;
    logic [XLEN-1:0]      result_q, result_d;
    logic [XLEN-1:0]      store_q, store_d;
    logic [XLEN-1:0]      npc_q, npc_d;
    logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
    logic [REG_IDX_W-1:0] rd_q, rd_d;

    logic [3:0]      op;
    logic [XLEN-1:0] op_b;
    logic            mul_load, mul_hold, mul_abort;
    logic            mul_busy, mul_done;
    logic [XLEN-1:0] mul_product;
    logic            unused_opcode_hi;

    assign op               = opcode_in[3:0];
    assign op_b             = y_sel_in ? immed_in : rgS2_data_in;
    assign unused_opcode_hi = ^{opcode_in[OPC_W-1:4], mul_busy};

    iter_mul u_mul (
        .clk       (clk),
        .reset     (reset),
        .load_i    (mul_load),
        .hold_i    (mul_hold),
        .abort_i   (mul_abort),
        .a_i       (rgS1_data_in),
        .b_i       (op_b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        result_d  = result_q;
        store_d   = store_q;
        npc_d     = npc_q;
        ctrl_d    = ctrl_q;
        rd_d      = rd_q;
        stall_out = 1'b0;
        mul_load  = 1'b0;
        mul_hold  = 1'b0;
        mul_abort = 1'b0;
        if (flush) begin
            state_d   = EX_IDLE;
            valid_d   = 1'b0;
            ctrl_d    = '0;
            mul_abort = 1'b1;
        end else if (mem_stall) begin
            stall_out = 1'b1;
            mul_hold  = 1'b1;
        end else begin
            case (state_q)
                EX_IDLE: begin
                    if (!in_valid) begin
                        valid_d = 1'b0;
                        ctrl_d  = '0;
                    end else if (op == ALU_MUL) begin
                        stall_out = 1'b1;
                        mul_load  = 1'b1;
                        state_d   = EX_MUL_BUSY;
                        valid_d   = 1'b0;
                        ctrl_d    = '0;
                    end else begin
                        valid_d  = 1'b1;
                        result_d = alu_compute(op, rgS1_data_in, op_b);
                        store_d  = rgS2_data_in;
                        npc_d    = next_pc_in;
                        ctrl_d   = control_in;
                        rd_d     = rgD_index_in;
                    end
                end
                EX_MUL_BUSY: begin
                    stall_out = 1'b1;
                    valid_d   = 1'b0;
                    if (mul_done) begin
                        state_d = EX_MUL_DONE;
                    end
                end
                EX_MUL_DONE: begin
                    // ID/EX was held through the multiply, so its fields still belong to this MUL.
                    valid_d  = 1'b1;
                    result_d = mul_product;
                    store_d  = rgS2_data_in;
                    npc_d    = next_pc_in;
                    ctrl_d   = control_in;
                    rd_d     = rgD_index_in;
                    state_d  = EX_IDLE;
                end
                default: state_d = EX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= EX_IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
            store_q  <= '0;
            npc_q    <= '0;
            ctrl_q   <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            store_q  <= store_d;
            npc_q    <= npc_d;
            ctrl_q   <= ctrl_d;
            rd_q     <= rd_d;
        end
    end

    assign out_valid      = valid_q;
    assign result_out     = result_q;
    assign store_data_out = store_q;
    assign next_pc_out    = npc_q;
    assign control_out    = ctrl_q;
    assign rgD_index_out  = rd_q;

endmodule

// File: doc/ex_unit.md
EX_UNIT -- requirements
Module: ex_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: `clk  in  1`, rising-edge clock; `reset  in  1`, synchronous, active-high.
REQ-002 The block SHALL have these ID/EX inputs:
  - `in_valid  in  1`: ID/EX slot holds a real instruction; 0 means bubble.
  - `next_pc_in  in  32`: PC of the next instruction.
  - `opcode_in  in  14`: [3:0] = ALU op; [13:4] ignored.
  - `rgS1_data_in  in  32`: operand A.
  - `rgS2_data_in  in  32`: register operand B and store data.
  - `immed_in  in  32`: immediate.
  - `y_sel_in  in  1`: 1 selects `immed_in` as operand B; 0 selects `rgS2_data_in`.
  - `control_in  in  6`: [0] read_mmu, [1] write_mmu, [2] byte_select_mmu, [3] write_reg, [5:4] reserved (passed through).
  - `rgD_index_in  in  5`: destination register.
REQ-003 The block SHALL have these control inputs: `flush  in  1` (kill in-flight work) and `mem_stall  in  1` (downstream MEM stage cannot accept).
REQ-004 The block SHALL have these outputs:
  - `stall_out  out  1`: hold ID/EX; ID/EX `write_enable` = ~`stall_out`.
  - `out_valid  out  1`.
  - `result_out  out  32`.
  - `store_data_out  out  32`.
  - `next_pc_out  out  32`.
  - `control_out  out  6`.
  - `rgD_index_out  out  5`.

Function
REQ-005 Operand B SHALL be `immed_in` when `y_sel_in`=1, else `rgS2_data_in`.
REQ-006 The ALU op SHALL be decoded as follows, with all arithmetic mod 2^32 and no overflow flag:
  - 0 ADD: A+B.
  - 1 SUB: A-B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLL: A<<B[4:0].
  - 6 SRL: logical A>>B[4:0].
  - 7 MUL: low 32 bits of A*B, unsigned.
  - 8-15: pass B.
REQ-007 All outputs except `stall_out` SHALL be registered (EX/MEM latch inside this block); `stall_out` SHALL be combinational.
REQ-008 The FSM SHALL have states IDLE, MUL_BUSY and MUL_DONE.
REQ-009 In IDLE with `in_valid`=1 and a non-MUL op, the result, `rgS2_data_in`, `next_pc_in`, `control_in` and `rgD_index_in` SHALL be latched at the next edge with `out_valid`=1 (1-cycle latency) and `stall_out`=0.
REQ-010 In IDLE with `in_valid`=1 and op=MUL:
  - `stall_out`=1 in that cycle.
  - Multiplier loaded and 5-bit counter cleared at the edge.
  - Next state MUL_BUSY.
  - `out_valid`=0 latched.
REQ-011 In MUL_BUSY the multiplier SHALL process one multiplier bit per cycle (shift-add) with `stall_out`=1 and `out_valid`=0, and SHALL move to MUL_DONE after 32 cycles (counter reaching 31).
REQ-012 In MUL_DONE `stall_out` SHALL be 0; at the edge the product and the still-held ID/EX fields SHALL be latched with `out_valid`=1, and the state SHALL return to IDLE.
REQ-013 MUL total occupancy SHALL be 34 cycles, with `stall_out` high for exactly 33 consecutive cycles.
REQ-014 When `in_valid`=0 in IDLE, the block SHALL latch `out_valid`=0 and `control_out`=0 (bubble: no register or memory write).
REQ-015 When `mem_stall`=1, all output registers, FSM state, counter and multiplier SHALL hold and `stall_out` SHALL be 1, regardless of state.
REQ-016 When `flush`=1, the block SHALL latch `out_valid`=0 and `control_out`=0, force the FSM to IDLE (aborting any MUL, discarding the partial product), and drive `stall_out`=0.
REQ-017 Priority SHALL be `reset` > `flush` > `mem_stall` > normal operation.
REQ-018 `opcode_in`[13:4] SHALL NOT affect behaviour.

Reset
REQ-019 On reset the block SHALL set:
  - State = IDLE, counter = 0, multiplier registers = 0.
  - `out_valid`=0, `result_out`=0, `store_data_out`=0, `next_pc_out`=0, `control_out`=0, `rgD_index_out`=0.
  - `stall_out`=0 in the following cycle unless a MUL is then presented.
REQ-020 Reset asserted mid-MUL SHALL abort it with no `out_valid` pulse.

Structure
REQ-021 The shared package `pipe_pkg` SHALL hold the ALU op encodings (0-15), the control bit positions (READ_MMU=0, WRITE_MMU=1, BYTE_SEL=2, WRITE_REG=3), and the widths 32/14/6/5.
REQ-022 The block SHALL contain one sub-module, `iter_mul`, a 32-cycle shift-add multiplier with load/busy/done signals and a hold (stall) input; the ALU and output latch SHALL reside in `ex_unit`.

Verification
REQ-023 ADD, `y_sel_in`=1, A=5, imm=0xFFFF_FFFF, `control_in`=0x08, rd=7 -> next cycle: `result_out`=4, `out_valid`=1, `control_out`=0x08, `rgD_index_out`=7, `stall_out` never high.
REQ-024 MUL, A=0x0001_0001, B=0x0001_0003 -> `stall_out` high 33 cycles, then `result_out`=0x0004_0003, `out_valid`=1 for one cycle.
REQ-025 MUL with `mem_stall` pulsed for 4 cycles during MUL_BUSY -> completion delayed by exactly 4 cycles, result unchanged.
REQ-026 `flush` at MUL_BUSY cycle 10 -> next cycle: IDLE, `stall_out`=0, no `out_valid`; a following ADD 2+3 -> `result_out`=5.
REQ-027 SLL, A=1, B=0x23 -> `result_out`=8; SRL, A=0x8000_0000, B=31 -> `result_out`=1.
REQ-028 Bubble (`in_valid`=0) with `control_in`=0x0F -> `control_out`=0, `out_valid`=0; reset during MUL -> all outputs 0 next cycle.
